// File: rtl/dds_ram_ctrl.sv
// dds_ram_ctrl: phase accumulator, waveform RAM read sequencer and host
// write arbiter sharing one single-port waveform RAM (3 x 1024 samples).
module dds_ram_ctrl #(
   parameter int PHASE_W   = 32,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int SEG_AW    = 10,
   parameter int NUM_WAVES = 3
) (
   input  logic               clka,
   input  logic               rst_n,
   input  logic               en,
   input  logic               phase_clr,
   input  logic [PHASE_W-1:0] fword,
   input  logic [SEG_AW-1:0]  pword,
   input  logic [1:0]         wave_sel,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               wr_gnt,
   output logic               ram_ena,
   output logic               ram_wea,
   output logic [ADDR_W-1:0]  ram_addra,
   output logic [DATA_W-1:0]  ram_dina,
   input  logic [DATA_W-1:0]  ram_douta,
   output logic [DATA_W-1:0]  dds_data,
   output logic               dds_valid,
   output logic [15:0]        drop_cnt
);

   typedef enum logic [1:0] {IDLE, RUN_RD, RUN_WR} state_t;

   state_t              state, next_state;
   logic [PHASE_W-1:0]  acc;
   logic [1:0]          wave_act;
   logic [PHASE_W:0]    acc_sum;
   logic                wrap;
   logic                wave_load;
   logic [SEG_AW-1:0]   seg_off;
   logic [ADDR_W-1:0]   rd_addr;
   logic                issue_rd;
   logic                issue_wr;
   logic                count_drop;
   logic                rd_p1;

   // Carry out of the accumulator add marks a phase wrap; only real when advancing.
   assign acc_sum   = {1'b0, acc} + {1'b0, fword};
   assign wrap      = en & acc_sum[PHASE_W];
   // Segment offset wraps naturally at 1024 through its width.
   assign seg_off   = acc[PHASE_W-1 -: SEG_AW] + pword;
   assign rd_addr   = (ADDR_W'(wave_act) << SEG_AW) + ADDR_W'(seg_off);
   // Waveform switches only at a phase boundary, on clear, or while idle; invalid selects are ignored.
   assign wave_load = (int'(wave_sel) < NUM_WAVES) && (wrap || phase_clr || state == IDLE);

   // State register.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= next_state;
      end
   end

   // Next-state logic: a host write may only steal the slot following a read.
   always_comb begin
      // NOTE: default first so no path leaves next_state unassigned (which would infer a latch).
      next_state = state;
      case (state)
         IDLE:    next_state = en ? RUN_RD : IDLE;
         RUN_RD:  if (!en)        next_state = IDLE;
                  else if (wr_req) next_state = RUN_WR;
                  else             next_state = RUN_RD;
         RUN_WR:  next_state = en ? RUN_RD : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: what the RAM port carries in the coming cycle.
   always_comb begin
      issue_rd   = 1'b0;
      issue_wr   = 1'b0;
      count_drop = 1'b0;
      case (next_state)
         RUN_RD:  issue_rd = 1'b1;
         RUN_WR:  begin
            issue_wr   = 1'b1;
            count_drop = 1'b1;
         end
         default: issue_wr = wr_req;
      endcase
   end

   // Registered RAM port, grant and lost-slot counter.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         ram_ena   <= 1'b0;
         ram_wea   <= 1'b0;
         ram_addra <= '0;
         ram_dina  <= '0;
         wr_gnt    <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         ram_ena <= issue_rd | issue_wr;
         ram_wea <= issue_wr;
         wr_gnt  <= issue_wr;
         if (issue_wr) begin
            ram_addra <= wr_addr;
            ram_dina  <= wr_data;
         end else if (issue_rd) begin
            ram_addra <= rd_addr;
         end
         if (count_drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Phase accumulator and active waveform segment.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         wave_act <= '0;
      end else begin
         if (phase_clr) begin
            acc <= '0;
         end else if (en) begin
            acc <= acc_sum[PHASE_W-1:0];
         end
         if (wave_load) begin
            wave_act <= wave_sel;
         end
      end
   end

   // Read return pipeline: capture RAM data two edges after the read is presented.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         rd_p1     <= 1'b0;
         dds_valid <= 1'b0;
         dds_data  <= '0;
      end else begin
         rd_p1     <= ram_ena & ~ram_wea;
         dds_valid <= rd_p1;
         if (rd_p1) begin
            dds_data <= ram_douta;
         end
      end
   end

endmodule

// File: tb/tb_dds_ram_ctrl.sv
// tb_dds_ram_ctrl: directed table, hand sequences and randomized run of
// dds_ram_ctrl against a cycle-level behavioural model and a RAM model.
module tb_dds_ram_ctrl;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        phase_clr = 1'b0;
   logic [31:0] fword = '0;
   logic [9:0]  pword = '0;
   logic [1:0]  wave_sel = '0;
   logic        wr_req = 1'b0;
   logic [11:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_gnt, ram_ena, ram_wea, dds_valid;
   logic [11:0] ram_addra;
   logic [7:0]  ram_dina, ram_douta, dds_data;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   dds_ram_ctrl dut (
      .clka(clka), .rst_n(rst_n), .en(en), .phase_clr(phase_clr), .fword(fword),
      .pword(pword), .wave_sel(wave_sel), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_gnt(wr_gnt), .ram_ena(ram_ena), .ram_wea(ram_wea),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
      .dds_data(dds_data), .dds_valid(dds_valid), .drop_cnt(drop_cnt)
   );

   always #5 clka = ~clka;

   // Waveform RAM: single port, registered read.
   logic [7:0] mem [0:3071];
   always @(posedge clka) begin
      if (ram_ena) begin
         if (ram_wea) mem[ram_addra] <= ram_dina;
         else         ram_douta <= mem[ram_addra];
      end
   end

   function automatic logic [7:0] tbl(input int a);
      return 8'((a * 37 + 11) ^ (a >> 4));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_acc;
   logic [1:0]  m_wave;
   bit          m_idle, m_last_rd;
   logic [15:0] m_drop;
   bit          m_p0_v, m_p1_v, m_valid;
   logic [7:0]  m_p0_d, m_p1_d, m_data;
   bit          m_ena, m_wea, m_gnt;
   logic [11:0] m_addr;
   logic [7:0]  m_din;
   logic [7:0]  ref_mem [0:3071];

   task automatic model_reset();
      m_acc = '0; m_wave = '0; m_idle = 1; m_last_rd = 0; m_drop = '0;
      m_p0_v = 0; m_p1_v = 0; m_valid = 0; m_p0_d = '0; m_p1_d = '0; m_data = '0;
      m_ena = 0; m_wea = 0; m_gnt = 0; m_addr = '0; m_din = '0;
   endtask

   // One clock edge of the specified behaviour, using the inputs present at the edge.
   task automatic model_step();
      bit do_wr, do_rd, wrap;
      int idx;
      do_wr = wr_req && (!en || m_last_rd);
      do_rd = en && !do_wr;
      idx   = int'(m_wave) * 1024 + (int'(m_acc >> 22) + int'(pword)) % 1024;
      m_valid = m_p1_v;
      if (m_p1_v) m_data = m_p1_d;
      m_p1_v = m_p0_v; m_p1_d = m_p0_d;
      m_p0_v = do_rd;  m_p0_d = do_rd ? ref_mem[idx] : 8'h00;
      m_ena = do_rd || do_wr; m_wea = do_wr; m_gnt = do_wr;
      if (do_wr) begin
         m_addr = wr_addr; m_din = wr_data; ref_mem[wr_addr] = wr_data;
         if (en && m_drop != 16'hFFFF) m_drop++;
      end else if (do_rd) begin
         m_addr = 12'(idx);
      end
      wrap = en && (longint'(m_acc) + longint'(fword) >= 64'h1_0000_0000);
      if ((wrap || phase_clr || m_idle) && wave_sel != 2'd3) m_wave = wave_sel;
      if (phase_clr)  m_acc = '0;
      else if (en)    m_acc = m_acc + fword;
      m_idle = !en; m_last_rd = do_rd;
   endtask

   task automatic compare_model();
      check("rnd_ena", ram_ena, m_ena);
      check("rnd_wea", ram_wea, m_wea);
      check("rnd_gnt", wr_gnt, m_gnt);
      if (m_ena) check("rnd_addr", ram_addra, m_addr);
      if (m_wea) check("rnd_dina", ram_dina, m_din);
      check("rnd_valid", dds_valid, m_valid);
      check("rnd_data", dds_data, m_data);
      check("rnd_drop", drop_cnt, m_drop);
   endtask

   task automatic cycle();
      @(posedge clka);
      model_step();
      #1;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ena"}, ram_ena, 0);
      check({tag, "_wea"}, ram_wea, 0);
      check({tag, "_addr"}, ram_addra, 0);
      check({tag, "_dina"}, ram_dina, 0);
      check({tag, "_gnt"}, wr_gnt, 0);
      check({tag, "_data"}, dds_data, 0);
      check({tag, "_valid"}, dds_valid, 0);
      check({tag, "_drop"}, drop_cnt, 0);
   endtask

   typedef struct {
      bit          en, req;
      logic [11:0] addr;
      logic [7:0]  data;
      bit          e_ena, e_wea, e_gnt, e_valid;
      logic [11:0] e_addr;
      logic [15:0] e_drop;
   } vec_t;

   vec_t vt [12];

   initial begin
      int n, gnts, reads;
      bit found;
      int exp;

      for (int i = 0; i < 3072; i++) begin
         mem[i] = tbl(i);
         ref_mem[i] = tbl(i);
      end
      model_reset();

      // Single write steals one slot, en falls with reads in flight, then an idle write burst.
      vt[0]  = '{1, 0, 12'h000, 8'h00, 1, 0, 0, 1, 12'h000, 16'd0};
      vt[1]  = '{1, 0, 12'h000, 8'h00, 1, 0, 0, 1, 12'h001, 16'd0};
      vt[2]  = '{1, 1, 12'h800, 8'hA5, 1, 1, 1, 1, 12'h800, 16'd1};
      vt[3]  = '{1, 0, 12'h800, 8'hA5, 1, 0, 0, 1, 12'h003, 16'd1};
      vt[4]  = '{1, 0, 12'h800, 8'hA5, 1, 0, 0, 0, 12'h004, 16'd1};
      vt[5]  = '{0, 0, 12'h800, 8'hA5, 0, 0, 0, 1, 12'h000, 16'd1};
      vt[6]  = '{0, 0, 12'h800, 8'hA5, 0, 0, 0, 1, 12'h000, 16'd1};
      for (int i = 7; i < 12; i++)
         vt[i] = '{0, 1, 12'(12'h801 + i), 8'(8'h50 + i), 1, 1, 1, 0, 12'(12'h801 + i), 16'd1};

      // Reset state.
      #3;
      reset_checks("reset");
      @(negedge clka);
      rst_n = 1'b1;

      // Sweep segment 0 at one sample per cycle.
      fword = 32'h0040_0000; pword = '0; wave_sel = 2'd0; en = 1'b1;
      for (int i = 0; i < 1027; i++) begin
         cycle();
         if (i <= 1024) begin
            check("sweep_ena", ram_ena, 1);
            check("sweep_addr", ram_addra, 12'(i % 1024));
         end
         check("sweep_valid", dds_valid, (i >= 2) ? 1 : 0);
         if (i >= 2) check("sweep_data", dds_data, tbl((i - 2) % 1024));
      end

      // Segment switch waits for the phase wrap; select 3 is ignored.
      found = 0;
      for (n = 0; n < 2000 && !found; n++) begin
         cycle();
         if (ram_addra == 12'd500) found = 1;
      end
      check("wait_addr500", found, 1);
      wave_sel = 2'd1;
      for (int k = 1; k <= 525; k++) begin
         cycle();
         check("switch_addr", ram_addra, 12'(500 + k));
      end
      wave_sel = 2'd3;
      for (int k = 526; k <= 1600; k++) begin
         cycle();
         exp = 1024 + (500 + k) % 1024;
         check("sel3_addr", ram_addra, 12'(exp));
      end

      // Phase clear realigns to segment 0 offset 0, then the vector table.
      wave_sel = 2'd0; phase_clr = 1'b1;
      cycle();
      phase_clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         en = vt[i].en; wr_req = vt[i].req; wr_addr = vt[i].addr; wr_data = vt[i].data;
         cycle();
         check($sformatf("vec%0d_ena", i), ram_ena, vt[i].e_ena);
         check($sformatf("vec%0d_wea", i), ram_wea, vt[i].e_wea);
         check($sformatf("vec%0d_gnt", i), wr_gnt, vt[i].e_gnt);
         check($sformatf("vec%0d_valid", i), dds_valid, vt[i].e_valid);
         check($sformatf("vec%0d_drop", i), drop_cnt, vt[i].e_drop);
         if (vt[i].e_ena) check($sformatf("vec%0d_addr", i), ram_addra, vt[i].e_addr);
         if (vt[i].e_wea) check($sformatf("vec%0d_dina", i), ram_dina, vt[i].data);
      end
      wr_req = 1'b0;

      // Continuous write requests while running: writes alternate with reads.
      en = 1'b1; wr_req = 1'b1; wr_addr = 12'h900; gnts = 0; reads = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (wr_gnt) begin
            gnts++;
            wr_addr = wr_addr + 12'd3; wr_data = 8'($urandom);
         end
         if (ram_ena && !ram_wea) reads++;
      end
      wr_req = 1'b0;
      check("burst_gnts", gnts, 10);
      check("burst_reads", reads, 10);
      check("burst_drop", drop_cnt, 11);

      // Asynchronous reset with a read in flight.
      for (int i = 0; i < 3; i++) cycle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      reset_checks("midrst");
      en = 1'b0;
      @(negedge clka);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("postrst_valid", dds_valid, 0);
      end

      // Phase clear while running: following read lands on pword in the selected segment.
      en = 1'b1; pword = 10'd37; wave_sel = 2'd1; fword = 32'h0040_0000;
      for (int i = 0; i < 5; i++) cycle();
      phase_clr = 1'b1;
      cycle();
      phase_clr = 1'b0;
      cycle();
      check("clr_addr", ram_addra, 12'(1024 + 37));

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) fword = $urandom();
         if ($urandom_range(0, 30) == 0) pword = 10'($urandom());
         if ($urandom_range(0, 20) == 0) wave_sel = 2'($urandom());
         en = ($urandom_range(0, 9) != 0);
         phase_clr = ($urandom_range(0, 60) == 0);
         if (!wr_req || wr_gnt) begin
            wr_req  = ($urandom_range(0, 3) == 0);
            wr_addr = 12'($urandom_range(0, 3071));
            wr_data = 8'($urandom());
         end else if ($urandom_range(0, 15) == 0) begin
            wr_req = 1'b0;
         end
         cycle();
         compare_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
